// File: rtl/regfile_sb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_if
//  Purpose  : Bundle of decode/writeback/issue signals between the pipeline
//             and the scoreboarded register file.
//  Modports : master - pipeline side (drives addresses, write and issue)
//             slave  - register file side (drives read data, hazards, count)
//  Signals  : raddr1..3 / rdata1..3  read ports
//             we, waddr, wdata        writeback port
//             issue, issue_addr       destination being marked pending
//             hazard1..3, stall       pending-read indications
//             pend_cnt                number of pending registers
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [ADDR_W-1:0] raddr3;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] rdata3;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              hazard1;
  logic              hazard2;
  logic              hazard3;
  logic              stall;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output raddr1, raddr2, raddr3, we, waddr, wdata, issue, issue_addr,
    input  rdata1, rdata2, rdata3, hazard1, hazard2, hazard3, stall, pend_cnt
  );

  modport slave (
    input  raddr1, raddr2, raddr3, we, waddr, wdata, issue, issue_addr,
    output rdata1, rdata2, rdata3, hazard1, hazard2, hazard3, stall, pend_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : General-purpose register file with three combinational read
//             ports, one synchronous write port and a pending-write
//             scoreboard (one pend bit per register plus a pending count).
//  Ports    : CLK   - clock, rising edge
//             Reset - asynchronous, active-low; clears registers/scoreboard
//             bus   - regfile_sb_if.slave (read, writeback, issue, hazards)
//  Params   : DATA_W   register width
//             ADDR_W   address width, NREG = 2**ADDR_W
//             ZERO_REG 1 = register 0 reads zero and is never written/pending
//  Macro    : REGFILE_BYPASS_EN - when defined, a same-cycle write to a read
//             address forwards wdata and masks that port's hazard
//             (write-first); otherwise reads are read-first.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input wire          CLK,
  input wire          Reset,
  regfile_sb_if.slave bus
);

  localparam int   c_NREG    = 1 << ADDR_W;
  localparam int   c_NPORT   = 3;
  localparam logic c_ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]  r_regs [c_NREG];
  logic [c_NREG-1:0]  r_pend;
  logic [ADDR_W:0]    r_pendCnt;

  logic               w_wrOk;
  logic               w_issOk;
  logic               w_cntInc;
  logic               w_cntDec;
  logic [c_NREG-1:0]  w_pendNext;
  logic [ADDR_W-1:0]  w_raddr  [c_NPORT];
  logic [DATA_W-1:0]  w_rdata  [c_NPORT];
  logic [c_NPORT-1:0] w_hazard;

  // Qualified write/issue. Gating with Reset keeps the bypass path from
  // presenting wdata while the file is held in reset.
  assign w_wrOk  = Reset && bus.we    && !(c_ZERO_EN && (bus.waddr == '0));
  assign w_issOk = Reset && bus.issue && !(c_ZERO_EN && (bus.issue_addr == '0));

  // Count tracks the population of pend: it rises only on a 0->1 issue and
  // falls only when a write clears a set bit that is not re-issued on the
  // same edge, so it can neither exceed the number of pendable registers
  // nor underflow.
  assign w_cntInc = w_issOk && !r_pend[bus.issue_addr];
  assign w_cntDec = w_wrOk && r_pend[bus.waddr] &&
                    !(w_issOk && (bus.issue_addr == bus.waddr));

  // Clear first, then set: a same-address issue overrides the writeback so
  // a back-to-back producer keeps the register pending.
  always_comb begin
    w_pendNext = r_pend;
    if (w_wrOk) begin
      w_pendNext[bus.waddr] = 1'b0;
    end
    if (w_issOk) begin
      w_pendNext[bus.issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_pend    <= '0;
      r_pendCnt <= '0;
    end else begin
      if (w_wrOk) begin
        r_regs[bus.waddr] <= bus.wdata;
      end
      r_pend    <= w_pendNext;
      r_pendCnt <= r_pendCnt + {{ADDR_W{1'b0}}, w_cntInc}
                             - {{ADDR_W{1'b0}}, w_cntDec};
    end
  end

  assign w_raddr[0] = bus.raddr1;
  assign w_raddr[1] = bus.raddr2;
  assign w_raddr[2] = bus.raddr3;

  for (genvar p = 0; p < c_NPORT; p++) begin : g_rdPort
    logic w_isZero;
    assign w_isZero = c_ZERO_EN && (w_raddr[p] == '0);
`ifdef REGFILE_BYPASS_EN
    logic w_byp;
    assign w_byp       = w_wrOk && (bus.waddr == w_raddr[p]);
    assign w_rdata[p]  = w_isZero ? '0 : (w_byp ? bus.wdata : r_regs[w_raddr[p]]);
    assign w_hazard[p] = r_pend[w_raddr[p]] && !w_byp;
`else
    assign w_rdata[p]  = w_isZero ? '0 : r_regs[w_raddr[p]];
    assign w_hazard[p] = r_pend[w_raddr[p]];
`endif
  end

  assign bus.rdata1   = w_rdata[0];
  assign bus.rdata2   = w_rdata[1];
  assign bus.rdata3   = w_rdata[2];
  assign bus.hazard1  = w_hazard[0];
  assign bus.hazard2  = w_hazard[1];
  assign bus.hazard3  = w_hazard[2];
  assign bus.stall    = |w_hazard;
  assign bus.pend_cnt = r_pendCnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb. Three instances: default
//             (32b x 32, zero reg), small (32b x 8, zero reg) for count
//             saturation, and 16b x 4 with ZERO_REG=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifM ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(3)) ifS ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(2)) ifZ ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dutM (.CLK(CLK), .Reset(Reset), .bus(ifM.slave));
  regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dutS (.CLK(CLK), .Reset(Reset), .bus(ifS.slave));
  regfile_sb #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0)) dutZ (.CLK(CLK), .Reset(Reset), .bus(ifZ.slave));

  localparam int c_RD1 = 0, c_RD2 = 1, c_RD3 = 2, c_HZ1 = 3, c_HZ2 = 4, c_HZ3 = 5;
  localparam int c_STALL = 6, c_CNT = 7, c_S_CNT = 8, c_S_RD1 = 9, c_S_HZ1 = 10;
  localparam int c_Z_RD1 = 11, c_Z_HZ1 = 12, c_Z_CNT = 13;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  iaddr;
    logic [4:0]  ra1, ra2, ra3;
    logic [31:0] e1, e2, e3;
    logic        h1, h2, h3;
    logic [5:0]  cnt;
  } vec_t;
  vec_t vt [7];

  function automatic logic [31:0] probe(int sel);
    case (sel)
      c_RD1:   return ifM.rdata1;
      c_RD2:   return ifM.rdata2;
      c_RD3:   return ifM.rdata3;
      c_HZ1:   return {31'b0, ifM.hazard1};
      c_HZ2:   return {31'b0, ifM.hazard2};
      c_HZ3:   return {31'b0, ifM.hazard3};
      c_STALL: return {31'b0, ifM.stall};
      c_CNT:   return {26'b0, ifM.pend_cnt};
      c_S_CNT: return {28'b0, ifS.pend_cnt};
      c_S_RD1: return ifS.rdata1;
      c_S_HZ1: return {31'b0, ifS.hazard1};
      c_Z_RD1: return {16'b0, ifZ.rdata1};
      c_Z_HZ1: return {31'b0, ifZ.hazard1};
      c_Z_CNT: return {29'b0, ifZ.pend_cnt};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push_exp(string n, int sel, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = probe(e.sel);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {we,waddr,wdata, issue,iaddr, ra1,ra2,ra3, e1,e2,e3, h1,h2,h3, cnt}
    vt[0] = '{1'b1, 5'd1,  32'hA5A5_0001, 1'b0, 5'd0, 5'd1,  5'd2, 5'd0,
              32'hA5A5_0001, 32'h0,      32'h0,         1'b0, 1'b0, 1'b0, 6'd0};
    vt[1] = '{1'b1, 5'd2,  32'h0000_1234, 1'b1, 5'd6, 5'd1,  5'd2, 5'd6,
              32'hA5A5_0001, 32'h1234,   32'h0,         1'b0, 1'b0, 1'b1, 6'd1};
    vt[2] = '{1'b1, 5'd31, 32'hFFFF_0000, 1'b1, 5'd6, 5'd31, 5'd6, 5'd0,
              32'hFFFF_0000, 32'h0,      32'h0,         1'b0, 1'b1, 1'b0, 6'd1};
    vt[3] = '{1'b1, 5'd6,  32'h0000_0066, 1'b1, 5'd8, 5'd6,  5'd8, 5'd2,
              32'h66,        32'h0,      32'h1234,      1'b0, 1'b1, 1'b0, 6'd1};
    vt[4] = '{1'b1, 5'd10, 32'h0000_0010, 1'b0, 5'd0, 5'd10, 5'd8, 5'd6,
              32'h10,        32'h0,      32'h66,        1'b0, 1'b1, 1'b0, 6'd1};
    vt[5] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0,  5'd0, 5'd8,
              32'h0,         32'h0,      32'h0,         1'b0, 1'b0, 1'b1, 6'd1};
    vt[6] = '{1'b1, 5'd8,  32'h0000_0088, 1'b0, 5'd0, 5'd8,  5'd1, 5'd31,
              32'h88,        32'hA5A5_0001, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 6'd0};

    ifM.we = 1'b0; ifM.waddr = '0; ifM.wdata = '0; ifM.issue = 1'b0; ifM.issue_addr = '0;
    ifM.raddr1 = 5'd1; ifM.raddr2 = 5'd2; ifM.raddr3 = 5'd31;
    ifS.we = 1'b0; ifS.waddr = '0; ifS.wdata = '0; ifS.issue = 1'b0; ifS.issue_addr = '0;
    ifS.raddr1 = '0; ifS.raddr2 = '0; ifS.raddr3 = '0;
    ifZ.we = 1'b0; ifZ.waddr = '0; ifZ.wdata = '0; ifZ.issue = 1'b0; ifZ.issue_addr = '0;
    ifZ.raddr1 = '0; ifZ.raddr2 = '0; ifZ.raddr3 = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    push_exp("reset rdata1", c_RD1, 32'h0);
    push_exp("reset rdata2", c_RD2, 32'h0);
    push_exp("reset rdata3", c_RD3, 32'h0);
    push_exp("reset hazard1", c_HZ1, 32'h0);
    push_exp("reset stall", c_STALL, 32'h0);
    push_exp("reset pend_cnt", c_CNT, 32'h0);
    push_exp("reset small pend_cnt", c_S_CNT, 32'h0);
    push_exp("reset nozero pend_cnt", c_Z_CNT, 32'h0);
    drain();
    Reset = 1'b1;
    #1;

    // Table-driven vectors: each row is one edge; outputs read after it
    for (int i = 0; i < 7; i++) begin
      ifM.we = vt[i].we; ifM.waddr = vt[i].waddr; ifM.wdata = vt[i].wdata;
      ifM.issue = vt[i].issue; ifM.issue_addr = vt[i].iaddr;
      ifM.raddr1 = vt[i].ra1; ifM.raddr2 = vt[i].ra2; ifM.raddr3 = vt[i].ra3;
      tick();
      ifM.we = 1'b0; ifM.issue = 1'b0;
      #1;
      push_exp($sformatf("row%0d rdata1", i), c_RD1, vt[i].e1);
      push_exp($sformatf("row%0d rdata2", i), c_RD2, vt[i].e2);
      push_exp($sformatf("row%0d rdata3", i), c_RD3, vt[i].e3);
      push_exp($sformatf("row%0d hazard1", i), c_HZ1, {31'b0, vt[i].h1});
      push_exp($sformatf("row%0d hazard2", i), c_HZ2, {31'b0, vt[i].h2});
      push_exp($sformatf("row%0d hazard3", i), c_HZ3, {31'b0, vt[i].h3});
      push_exp($sformatf("row%0d stall", i), c_STALL, {31'b0, vt[i].h1 | vt[i].h2 | vt[i].h3});
      push_exp($sformatf("row%0d pend_cnt", i), c_CNT, {26'b0, vt[i].cnt});
      drain();
    end

    // Scoreboard life cycle on r3
    ifM.raddr1 = 5'd3; ifM.raddr2 = 5'd1; ifM.raddr3 = 5'd2;
    ifM.issue = 1'b1; ifM.issue_addr = 5'd3;
    tick();
    ifM.issue = 1'b0;
    #1;
    push_exp("life hazard1 c1", c_HZ1, 32'h1);
    push_exp("life stall c1", c_STALL, 32'h1);
    push_exp("life pend_cnt c1", c_CNT, 32'h1);
    drain();
    tick();
    push_exp("life hazard1 c2", c_HZ1, 32'h1);
    push_exp("life stall c2", c_STALL, 32'h1);
    drain();
    ifM.we = 1'b1; ifM.waddr = 5'd3; ifM.wdata = 32'h1234_5678;
    #1;
`ifdef REGFILE_BYPASS_EN
    push_exp("life write-cycle hazard1", c_HZ1, 32'h0);
    push_exp("life write-cycle rdata1", c_RD1, 32'h1234_5678);
`else
    push_exp("life write-cycle hazard1", c_HZ1, 32'h1);
    push_exp("life write-cycle stall", c_STALL, 32'h1);
`endif
    drain();
    tick();
    ifM.we = 1'b0;
    #1;
    push_exp("life after rdata1", c_RD1, 32'h1234_5678);
    push_exp("life after hazard1", c_HZ1, 32'h0);
    push_exp("life after stall", c_STALL, 32'h0);
    push_exp("life after pend_cnt", c_CNT, 32'h0);
    drain();

    // Simultaneous issue and write of already-pending r9
    ifM.raddr1 = 5'd9;
    ifM.issue = 1'b1; ifM.issue_addr = 5'd9;
    tick();
    ifM.issue = 1'b0;
    #1;
    push_exp("r9 pending hazard1", c_HZ1, 32'h1);
    push_exp("r9 pending cnt", c_CNT, 32'h1);
    drain();
    ifM.issue = 1'b1; ifM.issue_addr = 5'd9;
    ifM.we = 1'b1; ifM.waddr = 5'd9; ifM.wdata = 32'h0000_0099;
    tick();
    ifM.issue = 1'b0; ifM.we = 1'b0;
    #1;
    push_exp("r9 issue+write hazard1", c_HZ1, 32'h1);
    push_exp("r9 issue+write cnt", c_CNT, 32'h1);
    push_exp("r9 issue+write rdata1", c_RD1, 32'h99);
    drain();
    ifM.we = 1'b1; ifM.waddr = 5'd9; ifM.wdata = 32'h0000_009A;
    tick();
    ifM.we = 1'b0;
    #1;
    push_exp("r9 final hazard1", c_HZ1, 32'h0);
    push_exp("r9 final cnt", c_CNT, 32'h0);
    push_exp("r9 final rdata1", c_RD1, 32'h9A);
    drain();

    // Bypass on r4 (r4=1 and pending, then written with 2)
    ifM.raddr2 = 5'd4;
    ifM.we = 1'b1; ifM.waddr = 5'd4; ifM.wdata = 32'h1;
    ifM.issue = 1'b1; ifM.issue_addr = 5'd4;
    tick();
    ifM.we = 1'b0; ifM.issue = 1'b0;
    #1;
    push_exp("byp setup rdata2", c_RD2, 32'h1);
    push_exp("byp setup hazard2", c_HZ2, 32'h1);
    push_exp("byp setup cnt", c_CNT, 32'h1);
    drain();
    ifM.we = 1'b1; ifM.waddr = 5'd4; ifM.wdata = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    push_exp("byp same-cycle rdata2", c_RD2, 32'h2);
    push_exp("byp same-cycle hazard2", c_HZ2, 32'h0);
`else
    push_exp("byp same-cycle rdata2", c_RD2, 32'h1);
    push_exp("byp same-cycle hazard2", c_HZ2, 32'h1);
`endif
    drain();
    tick();
    ifM.we = 1'b0;
    #1;
    push_exp("byp next rdata2", c_RD2, 32'h2);
    push_exp("byp next hazard2", c_HZ2, 32'h0);
    push_exp("byp next cnt", c_CNT, 32'h0);
    drain();

    // Reset mid-operation
    ifM.raddr1 = 5'd5; ifM.raddr2 = 5'd7; ifM.raddr3 = 5'd0;
    ifM.we = 1'b1; ifM.waddr = 5'd5; ifM.wdata = 32'hDEAD_BEEF;
    ifM.issue = 1'b1; ifM.issue_addr = 5'd7;
    tick();
    ifM.we = 1'b0; ifM.issue = 1'b0;
    #1;
    push_exp("prerst rdata1", c_RD1, 32'hDEAD_BEEF);
    push_exp("prerst hazard2", c_HZ2, 32'h1);
    push_exp("prerst cnt", c_CNT, 32'h1);
    drain();
    #1;
    Reset = 1'b0;
    #1;
    push_exp("midrst rdata1", c_RD1, 32'h0);
    push_exp("midrst hazard2", c_HZ2, 32'h0);
    push_exp("midrst stall", c_STALL, 32'h0);
    push_exp("midrst cnt", c_CNT, 32'h0);
    drain();
    ifM.we = 1'b1; ifM.waddr = 5'd5; ifM.wdata = 32'h55;
    ifM.issue = 1'b1; ifM.issue_addr = 5'd7;
    tick();
    push_exp("inrst rdata1", c_RD1, 32'h0);
    push_exp("inrst hazard2", c_HZ2, 32'h0);
    push_exp("inrst cnt", c_CNT, 32'h0);
    drain();
    ifM.we = 1'b0; ifM.issue = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    ifM.we = 1'b1; ifM.waddr = 5'd5; ifM.wdata = 32'h5A5A;
    tick();
    ifM.we = 1'b0;
    #1;
    push_exp("postrst rdata1", c_RD1, 32'h5A5A);
    drain();

    // Count saturation on the 8-register instance
    ifS.raddr1 = 3'd7;
    for (int k = 1; k < 8; k++) begin
      ifS.issue = 1'b1; ifS.issue_addr = 3'(k);
      tick();
      push_exp($sformatf("sat issue r%0d cnt", k), c_S_CNT, 32'(k));
      drain();
    end
    ifS.issue_addr = 3'd1;
    tick();
    push_exp("sat reissue r1 cnt", c_S_CNT, 32'd7);
    drain();
    ifS.issue_addr = 3'd0;
    tick();
    ifS.issue = 1'b0;
    push_exp("sat issue r0 cnt", c_S_CNT, 32'd7);
    push_exp("sat hazard r7", c_S_HZ1, 32'h1);
    drain();
    for (int k = 1; k < 8; k++) begin
      ifS.we = 1'b1; ifS.waddr = 3'(k); ifS.wdata = 32'(k * 16);
      tick();
      push_exp($sformatf("sat write r%0d cnt", k), c_S_CNT, 32'(7 - k));
      drain();
    end
    ifS.we = 1'b0;
    #1;
    push_exp("sat final rdata r7", c_S_RD1, 32'd112);
    push_exp("sat final hazard r7", c_S_HZ1, 32'h0);
    drain();

    // Register 0 as an ordinary register (ZERO_REG=0)
    ifZ.raddr1 = 2'd0;
    ifZ.we = 1'b1; ifZ.waddr = 2'd0; ifZ.wdata = 16'hBEEF;
    ifZ.issue = 1'b1; ifZ.issue_addr = 2'd0;
    tick();
    ifZ.we = 1'b0; ifZ.issue = 1'b0;
    #1;
    push_exp("nozero r0 rdata", c_Z_RD1, 32'hBEEF);
    push_exp("nozero r0 hazard", c_Z_HZ1, 32'h1);
    push_exp("nozero r0 cnt", c_Z_CNT, 32'h1);
    drain();
    ifZ.we = 1'b1; ifZ.waddr = 2'd0; ifZ.wdata = 16'h1111;
    tick();
    ifZ.we = 1'b0;
    #1;
    push_exp("nozero r0 rdata2", c_Z_RD1, 32'h1111);
    push_exp("nozero r0 hazard2", c_Z_HZ1, 32'h0);
    push_exp("nozero r0 cnt2", c_Z_CNT, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
